// File: rtl/reg_ctrl_sequencer.sv
// rtl/reg_ctrl_sequencer.sv - Moore sequencer driving X/Y/Z register codes and ALU select
module reg_ctrl_sequencer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [CNT_W-1:0] cnt,
    output logic [2:0]       tx,
    output logic [2:0]       ty,
    output logic [2:0]       tz,
    output logic             ula_sel,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] C_HOLD   = 3'b000;
    localparam logic [2:0] C_LOAD   = 3'b001;
    localparam logic [2:0] C_SHIFTR = 3'b010;
    localparam logic [2:0] C_SHIFTL = 3'b011;
    localparam logic [2:0] C_RESET  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic [2:0]       w_op_nxt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_is_shift;

    assign w_is_shift = (r_op == 3'b100) || (r_op == 3'b101);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 3'b000;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Shift ops stay in EXEC until the remaining count reaches zero, so cnt+1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_op_nxt    = opcode;
                    w_rem_nxt   = cnt;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_shift && (r_rem != '0)) begin
                    w_rem_nxt = r_rem - CNT_W'(1);
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx          = C_HOLD;
        ty          = C_HOLD;
        tz          = C_HOLD;
        ula_sel     = 1'b0;
        instr_ready = (r_state == S_IDLE);
        busy        = (r_state == S_EXEC) || (r_state == S_DONE);
        done        = (r_state == S_DONE);
        if (r_state == S_EXEC) begin
            case (r_op)
                3'b000: tx = C_LOAD;
                3'b001: ty = C_LOAD;
                3'b010: tz = C_LOAD;
                3'b011: begin
                    tz      = C_LOAD;
                    ula_sel = 1'b1;
                end
                3'b100: tx = C_SHIFTR;
                3'b101: tx = C_SHIFTL;
                3'b110: begin
                    tx = C_RESET;
                    ty = C_RESET;
                    tz = C_RESET;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// tb/tb_reg_ctrl_sequencer.sv - randomized and directed bench against a queue-based model
module tb_reg_ctrl_sequencer;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [2:0]       opcode = 3'b000;
    logic [CNT_W-1:0] cnt = '0;
    logic [2:0]       tx, ty, tz;
    logic             ula_sel, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    reg_ctrl_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .cnt(cnt), .tx(tx), .ty(ty), .tz(tz),
        .ula_sel(ula_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Output vector {ready, busy, done, ula_sel, tx, ty, tz}
    localparam logic [12:0] V_IDLE = 13'b1_0_0_0_000_000_000;
    localparam logic [12:0] V_DONE = 13'b0_1_1_0_000_000_000;

    logic [12:0] q[$];
    logic [12:0] dut_vec;
    assign dut_vec = {instr_ready, busy, done, ula_sel, tx, ty, tz};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] exec_vec(input logic [2:0] op);
        case (op)
            3'd0: return 13'b0_1_0_0_001_000_000;
            3'd1: return 13'b0_1_0_0_000_001_000;
            3'd2: return 13'b0_1_0_0_000_000_001;
            3'd3: return 13'b0_1_0_1_000_000_001;
            3'd4: return 13'b0_1_0_0_010_000_000;
            3'd5: return 13'b0_1_0_0_011_000_000;
            3'd6: return 13'b0_1_0_0_100_100_100;
            default: return 13'b0_1_0_0_000_000_000;
        endcase
    endfunction

    // Model: an accepted instruction becomes a list of future output vectors.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end else if (instr_valid) begin
            int n;
            n = (opcode == 3'd4 || opcode == 3'd5) ? int'(cnt) + 1 : 1;
            for (int i = 0; i < n; i++) q.push_back(exec_vec(opcode));
            q.push_back(V_DONE);
        end
    end

    always @(negedge clk) begin
        if (rst_n) chk("cycle_vec", 32'(dut_vec), 32'((q.size() > 0) ? q[0] : V_IDLE));
    end

    task automatic wait_idle();
        int k = 0;
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("idle_timeout", 32'(k), 32'(0));
    endtask

    // Leaves at the negedge of the first EXEC cycle.
    task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] c);
        @(negedge clk);
        wait_idle();
        instr_valid = 1'b1;
        opcode = op;
        cnt = c;
        @(negedge clk);
        instr_valid = 1'b0;
        opcode = 3'($urandom_range(0, 7));
        cnt = CNT_W'($urandom_range(0, 3));
    endtask

    initial begin
        int k;
        int dn;
        #1;
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_vec", 32'(dut_vec), 32'(13'b1_0_0_0_000_000_000));
        chk("model_ldx_vec", 32'(exec_vec(3'd0)), 32'(13'b0_1_0_0_001_000_000));
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'd0, 2'd0);
        chk("ldx_tx", 32'(tx), 32'd1);
        chk("ldx_tytz", 32'({ty, tz}), 32'd0);
        chk("ldx_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ldx_done", 32'(done), 32'd1);
        chk("ldx_tx_hold", 32'(tx), 32'd0);
        @(negedge clk);
        chk("ldx_ready", 32'(instr_ready), 32'd1);

        issue(3'd3, 2'd2);
        chk("sub_tz", 32'(tz), 32'd1);
        chk("sub_ula", 32'(ula_sel), 32'd1);
        chk("sub_txty", 32'({tx, ty}), 32'd0);
        @(negedge clk);
        chk("sub_done", 32'(done), 32'd1);
        chk("sub_tz_hold", 32'(tz), 32'd0);

        issue(3'd5, 2'd3);
        k = 0;
        while (tx == 3'b011 && k < 10) begin
            k++;
            @(negedge clk);
        end
        chk("shl_cycles", 32'(k), 32'd4);
        chk("shl_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("shl_done_pulse", 32'(done), 32'd0);

        issue(3'd4, 2'd0);
        k = 0;
        while (tx == 3'b010 && k < 10) begin
            k++;
            @(negedge clk);
        end
        chk("shr0_cycles", 32'(k), 32'd1);

        issue(3'd7, 2'd1);
        k = 1;
        dn = 0;
        chk("nop_codes", 32'({tx, ty, tz, ula_sel}), 32'd0);
        @(negedge clk);
        while (busy && k < 10) begin
            k++;
            if (done) dn++;
            chk("nop_codes", 32'({tx, ty, tz, ula_sel}), 32'd0);
            @(negedge clk);
        end
        chk("nop_busy_cycles", 32'(k), 32'd2);
        chk("nop_done_count", 32'(dn), 32'd1);

        // CLR held valid: one execution per 3-cycle window
        @(negedge clk);
        wait_idle();
        instr_valid = 1'b1;
        opcode = 3'd6;
        k = 0;
        repeat (9) begin
            @(negedge clk);
            if (tx == 3'd4 && ty == 3'd4 && tz == 3'd4) k++;
        end
        instr_valid = 1'b0;
        chk("clr_held_count", 32'(k), 32'd3);

        @(negedge clk);
        wait_idle();
        instr_valid = 1'b1;
        opcode = 3'd6;
        @(negedge clk);
        chk("clr_exec", 32'({tx, ty, tz}), 32'(9'b100_100_100));
        opcode = 3'd0;
        @(negedge clk);
        chk("clr_done_latched", 32'({done, tx, ty, tz}), 32'(10'b1_000_000_000));
        @(negedge clk);
        chk("clr_then_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        chk("ldx_after_clr", 32'({tx, ty}), 32'(6'b001_000));
        instr_valid = 1'b0;

        // Asynchronous reset in the middle of SHR cnt=3
        issue(3'd4, 2'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vec", 32'(dut_vec), 32'(13'b1_0_0_0_000_000_000));
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("async_rst_no_done", 32'(dn), 32'd0);

        // Randomized traffic; the compare process checks every cycle
        repeat (800) begin
            @(negedge clk);
            instr_valid = ($urandom_range(0, 3) != 0);
            opcode = 3'($urandom_range(0, 7));
            cnt = CNT_W'($urandom_range(0, 3));
        end
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_ctrl_sequencer.md
Name: reg_ctrl_sequencer

Overview:
- Control sequencer directly upstream of the X/Y/Z data registers and the ALU in the CPU datapath.
- Accepts one instruction (3-bit opcode plus shift count) per valid/ready handshake.
- Walks a Moore FSM and drives the 3-bit register control codes (tx, ty, tz) and the ALU select for the required number of cycles.
- Pulses done when the instruction has retired.

Parameters:
- CNT_W, 2, width of the shift-count field; a shift instruction performs cnt+1 shifts (1..2^CNT_W).

Ports:
- clk  input  1  rising-edge clock shared with the data registers
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  opcode/cnt presented this cycle
- instr_ready  output  1  sequencer can accept an instruction
- opcode  input  3  instruction opcode (map below)
- cnt  input  CNT_W  shift count field; ignored for non-shift opcodes
- tx  output  3  control code to register X
- ty  output  3  control code to register Y
- tz  output  3  control code to register Z
- ula_sel  output  1  ALU operation select: 0=ADD, 1=SUB
- busy  output  1  high in EXEC and DONE
- done  output  1  one-cycle pulse on instruction retire

Behaviour:
- Register control codes: HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, RESET=100.
- Opcode map:
  - 000 LDX: tx=LOAD
  - 001 LDY: ty=LOAD
  - 010 ADD: tz=LOAD, ula_sel=0
  - 011 SUB: tz=LOAD, ula_sel=1
  - 100 SHR: tx=SHIFTR
  - 101 SHL: tx=SHIFTL
  - 110 CLR: tx=ty=tz=RESET
  - 111 NOP: all HOLD
- Any code not listed for an opcode is HOLD.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; opcode/count registers cleared.
  - tx=ty=tz=000, ula_sel=0, busy=0, done=0, instr_ready=1 (immediately, not waiting for a clock edge).
  - Reset mid-instruction abandons it; no done pulse is produced.
- FSM states: IDLE, EXEC, DONE. All outputs decode from registered state only (Moore, no input-to-output paths).
- IDLE:
  - instr_ready=1; all codes HOLD.
  - On a clk edge with instr_valid=1, latch opcode and cnt, then go to EXEC.
  - Inputs are ignored when instr_valid=0.
- EXEC:
  - Drive the codes for the latched opcode; downstream registers act on the clk edge that ends each EXEC cycle.
  - Non-shift opcodes: exactly 1 EXEC cycle, then DONE.
  - SHR/SHL: remaining-count register starts at cnt. Each EXEC cycle: if remaining=0 go to DONE, else decrement and stay in EXEC. This gives cnt+1 EXEC cycles.
  - cnt=all-ones gives 2^CNT_W cycles; the counter must not wrap past 0.
- DONE: exactly 1 cycle; done=1, all codes HOLD, instr_ready=0; then IDLE.
- instr_ready is 0 in EXEC and DONE. instr_valid asserted then is ignored and not queued; the source must hold it until accepted.
- Latency from acceptance edge:
  - Non-shift: EXEC in cycle +1, done in cycle +2, instr_ready high in cycle +3.
  - Shift: done in cycle cnt+2.
- Back-to-back: minimum 3 cycles per non-shift instruction; a new instruction can be accepted on the first IDLE cycle.
- opcode/cnt changing while busy has no effect on the latched instruction.

Test Plan:
- Reset: assert rst_n=0 mid-cycle during EXEC of SHR cnt=3 -> all outputs go to reset values immediately without a clk edge; instr_ready=1; no done pulse follows.
- LDX: instr_valid=1, opcode=000 in IDLE -> next cycle tx=001, ty=tz=000, busy=1. Following cycle done=1, tx=000. Next cycle instr_ready=1.
- SUB: opcode=011 -> exactly one EXEC cycle with tz=001, ula_sel=1, tx=ty=000; done 2 cycles after acceptance.
- SHL: opcode=101, cnt=2'b11 -> tx=011 for exactly 4 consecutive cycles, then done=1 for 1 cycle. SHR cnt=0 -> tx=010 for exactly 1 cycle.
- Handshake under busy: hold instr_valid=1 with opcode=110 continuously -> CLR (tx=ty=tz=100) executes once per 3-cycle window. Changing opcode to 000 while in EXEC has no effect until the next acceptance.
- NOP: opcode=111 -> all codes 000 throughout; busy high for 2 cycles; done pulses once.
